// File: rtl/pipe_length_to_last.sv
`default_nettype none
// ============================================================================
// Module      : pipe_length_to_last
// Description : Converts a length-framed beat stream (beat count carried on
//               the first beat) into a last-flagged beat stream. A 2-entry
//               {data,last} FIFO decouples the two sides so both run at full
//               rate with a registered in_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_length_to_last #(
  parameter int DATA_WIDTH = 128,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [LEN_WIDTH-1:0]  in_length,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [31:0]           pkt_count,
  output logic                  len_zero_err
);

  localparam logic [LEN_WIDTH-1:0] c_len_zero = '0;
  localparam logic [LEN_WIDTH-1:0] c_len_one  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BODY = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic [LEN_WIDTH-1:0]  w_remaining_nxt;
  logic                  w_tag_last;
  logic                  w_len_zero;

  logic [DATA_WIDTH-1:0] r_mem_data [0:1];
  logic [1:0]            r_mem_last;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic [1:0]            w_count_nxt;
  logic                  r_in_ready;
  logic [31:0]           r_pkt_count;
  logic                  r_len_zero_err;

  logic                  w_wr;
  logic                  w_rd;

  assign w_wr = in_valid & r_in_ready;
  assign w_rd = (r_count != 2'd0) & out_ready;

  // Framing FSM state register; only moves on an accepted input beat.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_remaining <= c_len_zero;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  // Next-state and last-tag decode; a zero length is framed as a 1-beat packet.
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_tag_last      = 1'b0;
    w_len_zero      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tag_last = (in_length <= c_len_one);
        w_len_zero = (in_length == c_len_zero);
        if (w_wr && (in_length > c_len_one)) begin
          w_state_nxt     = S_BODY;
          w_remaining_nxt = in_length - c_len_one;
        end
      end
      S_BODY: begin
        w_tag_last = (r_remaining == c_len_one);
        if (w_wr) begin
          w_remaining_nxt = r_remaining - c_len_one;
          if (r_remaining == c_len_one) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_remaining_nxt = c_len_zero;
      end
    endcase
  end

  // Occupancy bookkeeping; a full FIFO never sees a write because in_ready is low.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_rd})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO storage and pointers; in_ready is registered from the next occupancy.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mem_data[0] <= '0;
      r_mem_data[1] <= '0;
      r_mem_last    <= 2'b00;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_count       <= 2'd0;
      r_in_ready    <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem_data[r_wr_ptr] <= in_data;
        r_mem_last[r_wr_ptr] <= w_tag_last;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_rd) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != 2'd2);
    end
  end

  // Packet counter on emitted last beats, and sticky zero-length flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pkt_count    <= 32'd0;
      r_len_zero_err <= 1'b0;
    end else begin
      if (w_rd && r_mem_last[r_rd_ptr]) begin
        r_pkt_count <= r_pkt_count + 32'd1;
      end
      if (w_wr && (r_state == S_IDLE) && w_len_zero) begin
        r_len_zero_err <= 1'b1;
      end
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = (r_count != 2'd0);
  assign out_data     = r_mem_data[r_rd_ptr];
  assign out_last     = r_mem_last[r_rd_ptr];
  assign pkt_count    = r_pkt_count;
  assign len_zero_err = r_len_zero_err;

endmodule
`default_nettype wire

// File: tb/tb_pipe_length_to_last.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_length_to_last
// Description : Directed self-checking bench for pipe_length_to_last.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_length_to_last;

  localparam int DW = 128;
  localparam int LW = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [LW-1:0] in_length = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [31:0]   pkt_count;
  logic          len_zero_err;

  int n_checks = 0;
  int n_errors = 0;
  bit rnd_ready = 1'b0;

  logic [DW-1:0] got_d [$];
  logic          got_l [$];
  logic [DW-1:0] exp_d [$];
  logic          exp_l [$];

  pipe_length_to_last #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_length    (in_length),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .pkt_count    (pkt_count),
    .len_zero_err (len_zero_err)
  );

  always #5 CLK = ~CLK;

  // Records every output beat whose handshake completes on the coming edge.
  always @(negedge CLK) begin
    if (!RST && out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_l.push_back(out_last);
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Presents one beat and returns #1 after the edge that accepted it.
  task automatic send(input logic [DW-1:0] d, input logic [LW-1:0] len);
    bit acc = 1'b0;
    int k = 0;
    in_valid  = 1'b1;
    in_data   = d;
    in_length = len;
    while (!acc && k < 2000) begin
      @(negedge CLK);
      acc = in_ready;
      tick();
      k++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_errors++;
      $error("FAIL send_timeout: observed not accepted expected accepted");
    end
  endtask

  task automatic drain();
    int k = 0;
    while (out_valid && k < 2000) begin
      tick();
      k++;
    end
    chk("drain_empty", {127'd0, out_valid}, '0);
  endtask

  task automatic cmp_queues(input string tag);
    chk({tag, "_count"}, got_d.size(), exp_d.size());
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      chk({tag, "_data"}, got_d[i], exp_d[i]);
      chk({tag, "_last"}, {127'd0, got_l[i]}, {127'd0, exp_l[i]});
    end
    got_d.delete(); got_l.delete(); exp_d.delete(); exp_l.delete();
  endtask

  initial begin
    logic [DW-1:0] d;
    int len;
    int npkt;

    // Reset state.
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_in_ready",  {127'd0, in_ready}, '0);
    chk("rst_out_valid", {127'd0, out_valid}, '0);
    chk("rst_out_data",  out_data, '0);
    chk("rst_out_last",  {127'd0, out_last}, '0);
    chk("rst_pkt_count", {96'd0, pkt_count}, '0);
    chk("rst_len_err",   {127'd0, len_zero_err}, '0);
    @(posedge CLK); #1;
    RST = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("in_ready_after_rst", {127'd0, in_ready}, 128'd1);

    // Length-3 packet A,B,C with one-cycle latency.
    send(128'hA, 16'd3);
    chk("p3_beat0", {out_valid, out_last, out_data}, {1'b1, 1'b0, 128'hA});
    send(128'hB, 16'd0);
    chk("p3_beat1", {out_valid, out_last, out_data}, {1'b1, 1'b0, 128'hB});
    send(128'hC, 16'd0);
    chk("p3_beat2", {out_valid, out_last, out_data}, {1'b1, 1'b1, 128'hC});
    tick();
    chk("p3_pkt_count", {96'd0, pkt_count}, 128'd1);
    chk("p3_empty", {127'd0, out_valid}, '0);

    // Back-to-back lengths 1,2,1; in_length on a body beat is ignored.
    send(128'hD0, 16'd1);
    chk("b2b_d0", {out_last, out_data}, {1'b1, 128'hD0});
    send(128'hD1, 16'd2);
    chk("b2b_d1", {out_last, out_data}, {1'b0, 128'hD1});
    send(128'hD2, 16'd7);
    chk("b2b_d2", {out_last, out_data}, {1'b1, 128'hD2});
    send(128'hD3, 16'd1);
    chk("b2b_d3", {out_last, out_data}, {1'b1, 128'hD3});
    drain();
    chk("b2b_pkt_count", {96'd0, pkt_count}, 128'd4);

    // Zero length is a 1-beat packet and sets the sticky flag.
    send(128'h2, 16'd0);
    chk("zero_beat", {out_last, out_data}, {1'b1, 128'h2});
    chk("zero_err_set", {127'd0, len_zero_err}, 128'd1);
    send(128'h31, 16'd2);
    send(128'h32, 16'd0);
    drain();
    chk("zero_err_sticky", {127'd0, len_zero_err}, 128'd1);
    chk("zero_pkt_count", {96'd0, pkt_count}, 128'd6);

    // Backpressure: only two beats enter while the sink stalls.
    got_d.delete(); got_l.delete();
    out_ready = 1'b0;
    send(128'hE0, 16'd4);
    send(128'hE1, 16'd0);
    chk("bp_in_ready_low", {127'd0, in_ready}, '0);
    in_valid = 1'b1; in_data = 128'hE2; in_length = 16'd0;
    repeat (3) tick();
    chk("bp_still_blocked", {out_valid, in_ready, out_data}, {1'b1, 1'b0, 128'hE0});
    out_ready = 1'b1;
    send(128'hE2, 16'd0);
    send(128'hE3, 16'd0);
    drain();
    exp_d = '{128'hE0, 128'hE1, 128'hE2, 128'hE3};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
    cmp_queues("bp");
    chk("bp_pkt_count", {96'd0, pkt_count}, 128'd7);

    // Random stalls on both sides against a scoreboard.
    rnd_ready = 1'b1;
    npkt = 60;
    for (int p = 0; p < npkt; p++) begin
      len = $urandom_range(1, 40);
      for (int b = 0; b < len; b++) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        exp_d.push_back(d);
        exp_l.push_back(b == len - 1);
        repeat ($urandom_range(0, 2)) tick();
        send(d, (b == 0) ? LW'(len) : LW'($urandom));
      end
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    drain();
    cmp_queues("rnd");
    chk("rnd_pkt_count", {96'd0, pkt_count}, 128'd67);

    // Reset in the middle of a packet discards it.
    out_ready = 1'b0;
    send(128'hF0, 16'd5);
    send(128'hF1, 16'd0);
    RST = 1'b1;
    tick();
    chk("mid_rst_out_valid", {127'd0, out_valid}, '0);
    chk("mid_rst_pkt_count", {96'd0, pkt_count}, '0);
    chk("mid_rst_len_err", {127'd0, len_zero_err}, '0);
    RST = 1'b0;
    out_ready = 1'b1;
    got_d.delete(); got_l.delete();
    send(128'h6, 16'd1);
    chk("mid_rst_first_beat", {out_valid, out_last, out_data}, {1'b1, 1'b1, 128'h6});
    drain();
    chk("mid_rst_pkt_after", {96'd0, pkt_count}, 128'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #5000000;
    $display("FAIL global_timeout: observed still running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
